// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: memory geometry, queue entry layout and FSM encoding.
package fetch_ctrl_pkg;

  localparam int INST_LEN      = 32;
  localparam int MEMI_SIZE_LOG = 3;
  localparam int MEMI_SIZE     = 1 << MEMI_SIZE_LOG;
  localparam int FQ_ENTRY_LEN  = INST_LEN + MEMI_SIZE_LOG;

  localparam logic [MEMI_SIZE_LOG-1:0] MEMI_LAST_PC = MEMI_SIZE_LOG'(MEMI_SIZE - 1);

  typedef enum logic [0:0] {
    FETCH_ST_RUN  = 1'b0,
    FETCH_ST_HALT = 1'b1
  } fetch_st_e;

  typedef struct packed {
    logic [INST_LEN-1:0]      inst;
    logic [MEMI_SIZE_LOG-1:0] pc;
  } fq_entry_t;

  // PC increment; the natural width overflow gives the modulo-size wrap.
  function automatic logic [MEMI_SIZE_LOG-1:0] next_pc(input logic [MEMI_SIZE_LOG-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch stage bus: memi read port, decode-side dequeue handshake, redirect and status.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic [MEMI_SIZE_LOG-1:0] memi_req_addr;
  logic [INST_LEN-1:0]      memi_resp_data;
  logic                     deq_valid;
  logic                     deq_ready;
  logic [INST_LEN-1:0]      deq_inst;
  logic [MEMI_SIZE_LOG-1:0] deq_pc;
  logic                     redirect_valid;
  logic [MEMI_SIZE_LOG-1:0] redirect_pc;
  logic                     halted;
  logic [31:0]              stat_fetched;

  // The fetch controller side.
  modport master (
    output memi_req_addr, deq_valid, deq_inst, deq_pc, halted, stat_fetched,
    input  memi_resp_data, deq_ready, redirect_valid, redirect_pc
  );

  // The memory / decode / branch-unit side.
  modport slave (
    input  memi_req_addr, deq_valid, deq_inst, deq_pc, halted, stat_fetched,
    output memi_resp_data, deq_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Generic in-order FIFO with flush, occupancy count and registered full/empty flags.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  // Full is registered, so a push is refused while full even if a pop fires this cycle.
  assign push_ok = push && !full_q && !flush;
  assign pop_ok  = pop  && !empty_q && !flush;

  // Next occupancy: +1 on push only, -1 on pop only, unchanged when both fire.
  always_comb begin
    // NOTE: assign a default before any conditional so no latch is inferred.
    count_next = count_q;
    if (push_ok && !pop_ok) begin
      count_next = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_next = count_q - 1'b1;
    end
  end

  // Pointer, count and flag state; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) tail_q <= tail_q + 1'b1;
      if (pop_ok)  head_q <= head_q + 1'b1;
      count_q <= count_next;
      full_q  <= (count_next == CNT_W'(DEPTH));
      empty_q <= (count_next == '0);
    end
  end

  // Entry storage, cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    // NOTE: the storage is deliberately reset; this keeps deq outputs defined, at the cost of reset fan-out.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[tail_q] <= push_data;
    end
  end

  assign head_data = mem[head_q];
  assign count     = count_q;
  assign full      = full_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, run/halt FSM, redirect handling and fetch statistics.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                       FQ_DEPTH    = 4,
  parameter bit                       HALT_AT_END = 1'b1,
  parameter logic [MEMI_SIZE_LOG-1:0] RESET_PC    = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);

  localparam int FQ_CNT_W = $clog2(FQ_DEPTH) + 1;

  fetch_st_e                state_q;
  logic [MEMI_SIZE_LOG-1:0] pc_q;
  logic                     halted_q;
  logic [31:0]              stat_q;

  logic                     fq_full;
  logic [FQ_CNT_W-1:0]      fq_count;
  fq_entry_t                fq_head;
  fq_entry_t                fq_push_entry;
  logic                     fetch_fire;
  logic                     deq_valid;
  logic                     deq_fire;

  // A redirect suppresses both enqueue and dequeue and masks the head combinationally.
  assign fetch_fire = (state_q == FETCH_ST_RUN) && !bus.redirect_valid && !fq_full;
  assign deq_valid  = (fq_count != '0) && !bus.redirect_valid;
  assign deq_fire   = deq_valid && bus.deq_ready;

  assign fq_push_entry.inst = bus.memi_resp_data;
  assign fq_push_entry.pc   = pc_q;

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (FQ_ENTRY_LEN)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (fetch_fire),
    .push_data (fq_push_entry),
    .pop       (deq_fire),
    .head_data (fq_head),
    .count     (fq_count),
    .full      (fq_full)
  );

  // PC and run/halt FSM: redirect restarts fetch, the last address optionally halts.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      state_q  <= FETCH_ST_RUN;
      halted_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_q     <= bus.redirect_pc;
      state_q  <= FETCH_ST_RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH_ST_RUN: begin
          if (fetch_fire) begin
            pc_q <= next_pc(pc_q);
            if (HALT_AT_END && (pc_q == MEMI_LAST_PC)) begin
              state_q  <= FETCH_ST_HALT;
              halted_q <= 1'b1;
            end
          end
        end
        FETCH_ST_HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= FETCH_ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of enqueued instructions; flushes do not subtract.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else if (fetch_fire && (stat_q != '1)) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign bus.memi_req_addr = pc_q;
  assign bus.deq_valid     = deq_valid;
  assign bus.deq_inst      = fq_head.inst;
  assign bus.deq_pc        = fq_head.pc;
  assign bus.halted        = halted_q;
  assign bus.stat_fetched  = stat_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: one halting and one wrapping instance share clk/rst.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if ia ();
  fetch_ctrl_if ib ();

  logic [INST_LEN-1:0] prog [MEMI_SIZE];

  // Combinational memi model shared by both instances.
  assign ia.memi_resp_data = prog[ia.memi_req_addr];
  assign ib.memi_resp_data = prog[ib.memi_req_addr];

  fetch_ctrl #(.FQ_DEPTH(4), .HALT_AT_END(1'b1), .RESET_PC(3'd0)) dut_halt (
    .clk (clk), .rst (rst), .bus (ia)
  );
  fetch_ctrl #(.FQ_DEPTH(4), .HALT_AT_END(1'b0), .RESET_PC(3'd0)) dut_wrap (
    .clk (clk), .rst (rst), .bus (ib)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [MEMI_SIZE_LOG-1:0] sb_a [$];
  logic [MEMI_SIZE_LOG-1:0] sb_b [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit ready_a, input bit ready_b);
    rst = 1'b1;
    ia.deq_ready = ready_a; ia.redirect_valid = 1'b0; ia.redirect_pc = '0;
    ib.deq_ready = ready_b; ib.redirect_valid = 1'b0; ib.redirect_pc = '0;
    sb_a.delete();
    sb_b.delete();
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic push_range(input bit sel, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) sb_b.push_back(MEMI_SIZE_LOG'(first + i));
      else     sb_a.push_back(MEMI_SIZE_LOG'(first + i));
    end
  endtask

  // Pop/compare every dequeue until the scoreboard empties; optionally flag idle cycles.
  task automatic drain(input bit sel, input int budget, input bit gap_check);
    logic                     v, r;
    logic [MEMI_SIZE_LOG-1:0] p, e;
    logic [INST_LEN-1:0]      ins;
    int                       c = 0;
    while ((sel ? sb_b.size() : sb_a.size()) != 0) begin
      if (c == budget) begin
        n_cmp++; n_err++;
        $display("FAIL drain_timeout sel=%0d: %0d entries never dequeued", sel,
                 sel ? sb_b.size() : sb_a.size());
        break;
      end
      v   = sel ? ib.deq_valid : ia.deq_valid;
      r   = sel ? ib.deq_ready : ia.deq_ready;
      p   = sel ? ib.deq_pc    : ia.deq_pc;
      ins = sel ? ib.deq_inst  : ia.deq_inst;
      if (v && r) begin
        e = sel ? sb_b.pop_front() : sb_a.pop_front();
        n_cmp++;
        if (p !== e || ins !== prog[e]) begin
          n_err++;
          $display("FAIL deq_order sel=%0d: got pc=%0d inst=%h want pc=%0d inst=%h",
                   sel, p, ins, e, prog[e]);
        end
      end else if (gap_check) begin
        n_cmp++; n_err++;
        $display("FAIL deq_gap sel=%0d: deq_valid=%0b while pc=%0d still expected", sel, v,
                 sel ? sb_b[0] : sb_a[0]);
      end
      step();
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ia.deq_ready = 1'b1; ia.redirect_valid = 1'b0; ia.redirect_pc = '0;
    ib.deq_ready = 1'b1; ib.redirect_valid = 1'b0; ib.redirect_pc = '0;
    step();
    step();
    n_cmp++;
    if ({ia.deq_valid, ia.halted, ia.memi_req_addr, ia.deq_pc} !== 8'b0 ||
        ia.deq_inst !== '0 || ia.stat_fetched !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: valid=%0b halted=%0b addr=%0d pc=%0d inst=%h stat=%0d want all 0",
               ia.deq_valid, ia.halted, ia.memi_req_addr, ia.deq_pc, ia.deq_inst, ia.stat_fetched);
    end
  endtask

  task automatic test_stream_and_halt();
    do_reset(1'b1, 1'b0);
    n_cmp++;
    if (ia.deq_valid !== 1'b0) begin
      n_err++; $display("FAIL stream_cycle0_valid: got %0b want 0", ia.deq_valid);
    end
    push_range(1'b0, 0, 8);
    step();
    n_cmp++;
    if (ia.deq_valid !== 1'b1 || ia.deq_pc !== 3'd0 || ia.deq_inst !== 32'h0000_2083) begin
      n_err++;
      $display("FAIL stream_latency: got valid=%0b pc=%0d inst=%h want 1/0/00002083",
               ia.deq_valid, ia.deq_pc, ia.deq_inst);
    end
    drain(1'b0, 20, 1'b1);
    n_cmp++;
    if (ia.halted !== 1'b1 || ia.stat_fetched !== 32'd8 || ia.deq_valid !== 1'b0 ||
        ia.memi_req_addr !== 3'd0) begin
      n_err++;
      $display("FAIL halt_state: got halted=%0b stat=%0d valid=%0b addr=%0d want 1/8/0/0",
               ia.halted, ia.stat_fetched, ia.deq_valid, ia.memi_req_addr);
    end
    repeat (3) step();
    n_cmp++;
    if (ia.stat_fetched !== 32'd8 || ia.deq_valid !== 1'b0) begin
      n_err++;
      $display("FAIL halt_no_fetch: got stat=%0d valid=%0b want 8/0", ia.stat_fetched, ia.deq_valid);
    end
    // Redirect out of HALT.
    ia.redirect_valid = 1'b1;
    ia.redirect_pc    = 3'd2;
    step();
    ia.redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (ia.halted !== 1'b0 || ia.memi_req_addr !== 3'd2) begin
      n_err++;
      $display("FAIL halt_redirect: got halted=%0b addr=%0d want 0/2", ia.halted, ia.memi_req_addr);
    end
    push_range(1'b0, 2, 6);
    step();
    n_cmp++;
    if (ia.deq_valid !== 1'b1 || ia.deq_pc !== 3'd2) begin
      n_err++;
      $display("FAIL halt_redirect_head: got valid=%0b pc=%0d want 1/2", ia.deq_valid, ia.deq_pc);
    end
    drain(1'b0, 20, 1'b1);
  endtask

  task automatic test_backpressure();
    do_reset(1'b0, 1'b0);
    repeat (8) step();
    n_cmp++;
    if (ia.memi_req_addr !== 3'd4 || ia.stat_fetched !== 32'd4 ||
        ia.deq_valid !== 1'b1 || ia.deq_pc !== 3'd0) begin
      n_err++;
      $display("FAIL backpressure_full: got addr=%0d stat=%0d valid=%0b pc=%0d want 4/4/1/0",
               ia.memi_req_addr, ia.stat_fetched, ia.deq_valid, ia.deq_pc);
    end
    ia.deq_ready = 1'b1;
    #1;
    push_range(1'b0, 0, 8);
    drain(1'b0, 20, 1'b1);
  endtask

  task automatic test_redirect();
    do_reset(1'b0, 1'b0);
    repeat (3) step();
    ia.deq_ready      = 1'b1;
    ia.redirect_valid = 1'b1;
    ia.redirect_pc    = 3'd5;
    #1;
    n_cmp++;
    if (ia.deq_valid !== 1'b0) begin
      n_err++; $display("FAIL redirect_mask: got deq_valid=%0b want 0", ia.deq_valid);
    end
    step();
    ia.redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (ia.deq_valid !== 1'b0 || ia.memi_req_addr !== 3'd5) begin
      n_err++;
      $display("FAIL redirect_flush: got valid=%0b addr=%0d want 0/5", ia.deq_valid, ia.memi_req_addr);
    end
    push_range(1'b0, 5, 3);
    step();
    n_cmp++;
    if (ia.deq_valid !== 1'b1 || ia.deq_pc !== 3'd5) begin
      n_err++;
      $display("FAIL redirect_head: got valid=%0b pc=%0d want 1/5", ia.deq_valid, ia.deq_pc);
    end
    drain(1'b0, 10, 1'b1);
    n_cmp++;
    if (ia.stat_fetched !== 32'd6) begin
      n_err++; $display("FAIL redirect_stat: got %0d want 6", ia.stat_fetched);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0, 1'b1);
    push_range(1'b1, 0, 11);
    step();
    drain(1'b1, 30, 1'b1);
    n_cmp++;
    if (ib.halted !== 1'b0 || ib.memi_req_addr !== 3'd4 || ib.stat_fetched !== 32'd12) begin
      n_err++;
      $display("FAIL wrap_state: got halted=%0b addr=%0d stat=%0d want 0/4/12",
               ib.halted, ib.memi_req_addr, ib.stat_fetched);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0, 1'b0);
    repeat (6) step();
    rst               = 1'b1;
    ia.redirect_valid = 1'b1;
    ia.redirect_pc    = 3'd5;
    step();
    rst               = 1'b0;
    ia.redirect_valid = 1'b0;
    #1;
    n_cmp++;
    if (ia.deq_valid !== 1'b0 || ia.memi_req_addr !== 3'd0 || ia.stat_fetched !== 32'd0 ||
        ia.halted !== 1'b0 || ia.deq_inst !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got valid=%0b addr=%0d stat=%0d halted=%0b inst=%h want 0/0/0/0/0",
               ia.deq_valid, ia.memi_req_addr, ia.stat_fetched, ia.halted, ia.deq_inst);
    end
  endtask

  task automatic test_back_to_back();
    logic [MEMI_SIZE_LOG-1:0] e;
    do_reset(1'b0, 1'b0);
    repeat (2) step();
    ia.deq_ready = 1'b1;
    #1;
    push_range(1'b0, 0, 8);
    // Occupancy held at 2 shows up as the fetch PC leading the head PC by exactly 2.
    for (int k = 0; k < 5; k++) begin
      e = sb_a.pop_front();
      n_cmp++;
      if (ia.deq_valid !== 1'b1 || ia.deq_pc !== e || ia.deq_inst !== prog[e] ||
          ia.memi_req_addr !== MEMI_SIZE_LOG'(e + 3'd2)) begin
        n_err++;
        $display("FAIL back_to_back k=%0d: got valid=%0b pc=%0d addr=%0d want 1/%0d/%0d",
                 k, ia.deq_valid, ia.deq_pc, ia.memi_req_addr, e, MEMI_SIZE_LOG'(e + 3'd2));
      end
      step();
    end
    drain(1'b0, 10, 1'b1);
  endtask

  initial begin
    prog[0] = 32'h0000_2083;
    for (int i = 1; i < MEMI_SIZE; i++) prog[i] = 32'h0000_0093 | (32'(i) << 20);
    test_reset();
    test_stream_and_halt();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
